// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - PS/2 scan-code set 2 and Hack keycode constants shared by the keyboard slice
// Contents: scan-code prefixes, shift scan codes, Hack special-key codes, rx FSM state type,
// and the plain/upper keycode pair returned by the translation function.
package ps2_pkg;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_PAUSE  = 8'hE1;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;

    localparam logic [7:0] KEY_NEWLINE   = 8'd128;
    localparam logic [7:0] KEY_BACKSPACE = 8'd129;
    localparam logic [7:0] KEY_LEFT      = 8'd130;
    localparam logic [7:0] KEY_UP        = 8'd131;
    localparam logic [7:0] KEY_RIGHT     = 8'd132;
    localparam logic [7:0] KEY_DOWN      = 8'd133;
    localparam logic [7:0] KEY_HOME      = 8'd134;
    localparam logic [7:0] KEY_END       = 8'd135;
    localparam logic [7:0] KEY_PGUP      = 8'd136;
    localparam logic [7:0] KEY_PGDN      = 8'd137;
    localparam logic [7:0] KEY_INSERT    = 8'd138;
    localparam logic [7:0] KEY_DELETE    = 8'd139;
    localparam logic [7:0] KEY_ESC       = 8'd140;
    localparam logic [7:0] KEY_F1        = 8'd141;
    localparam logic [7:0] KEY_F2        = 8'd142;
    localparam logic [7:0] KEY_F3        = 8'd143;
    localparam logic [7:0] KEY_F4        = 8'd144;
    localparam logic [7:0] KEY_F5        = 8'd145;
    localparam logic [7:0] KEY_F6        = 8'd146;
    localparam logic [7:0] KEY_F7        = 8'd147;
    localparam logic [7:0] KEY_F8        = 8'd148;
    localparam logic [7:0] KEY_F9        = 8'd149;
    localparam logic [7:0] KEY_F10       = 8'd150;
    localparam logic [7:0] KEY_F11       = 8'd151;
    localparam logic [7:0] KEY_F12       = 8'd152;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // plain = unshifted result, upper = shifted result; both 0 for untranslated codes
    typedef struct packed {
        logic [7:0] plain;
        logic [7:0] upper;
    } key_pair_t;

endpackage

// File: rtl/ps2_keyboard_if.sv
// rtl/ps2_keyboard_if.sv - keyboard result bus towards the Memory KBD register
// Signals: keycode[15:0] (held key, 0 when none), byte_valid (good frame pulse),
// frame_error (bad frame / timeout pulse). master = keyboard, slave = consumer.
interface ps2_keyboard_if ();
    logic [15:0] keycode;
    logic        byte_valid;
    logic        frame_error;

    modport master (output keycode, byte_valid, frame_error);
    modport slave  (input  keycode, byte_valid, frame_error);
endinterface

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 frame receiver: 2-FF sync, clock glitch filter, rx FSM, frame timeout
// Ports: clk, reset (sync, active high), ps2_clk/ps2_data (raw async pins),
// rx_byte (last received byte, valid with byte_valid), byte_valid (1-cycle pulse one cycle
// after the stop-bit edge), frame_error (1-cycle pulse on bad start/parity/stop or timeout).
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_error
);

    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

    logic           clk_meta, clk_sync, dat_meta, dat_sync;
    logic           filt_q;
    logic [FCW-1:0] fcnt_q;
    logic           fall;

    rx_state_t      state_q, state_d;
    logic [7:0]     shift_q, shift_d;
    logic [2:0]     bit_q, bit_d;
    logic           par_q, par_d;
    logic [TCW-1:0] tmo_q, tmo_d;
    logic           valid_d, error_d;

    // The filtered clock only follows the synchronised pin after FILTER_LEN consecutive
    // samples that disagree with it; any agreeing sample restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_meta <= 1'b1;
            clk_sync <= 1'b1;
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
            filt_q   <= 1'b1;
            fcnt_q   <= '0;
        end else begin
            clk_meta <= ps2_clk;
            clk_sync <= clk_meta;
            dat_meta <= ps2_data;
            dat_sync <= dat_meta;
            if (clk_sync == filt_q) begin
                fcnt_q <= '0;
            end else if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
                filt_q <= clk_sync;
                fcnt_q <= '0;
            end else begin
                fcnt_q <= fcnt_q + FCW'(1);
            end
        end
    end

    // Falling edge is flagged in the same cycle the filtered level flips to 0.
    assign fall = filt_q && !clk_sync && (fcnt_q == FCW'(FILTER_LEN - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RX_IDLE;
            shift_q     <= '0;
            bit_q       <= '0;
            par_q       <= 1'b0;
            tmo_q       <= '0;
            byte_valid  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_q       <= bit_d;
            par_q       <= par_d;
            tmo_q       <= tmo_d;
            byte_valid  <= valid_d;
            frame_error <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        par_d   = par_q;
        valid_d = 1'b0;
        error_d = 1'b0;
        tmo_d   = (state_q == RX_IDLE || fall) ? '0 : tmo_q + TCW'(1);

        case (state_q)
            RX_IDLE: begin
                // A high start bit is treated as line noise, not an error.
                if (fall && !dat_sync) begin
                    state_d = RX_DATA;
                    bit_d   = '0;
                end
            end
            RX_DATA: begin
                if (fall) begin
                    shift_d = {dat_sync, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = RX_PARITY;
                end
            end
            RX_PARITY: begin
                if (fall) begin
                    par_d   = dat_sync;
                    state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (fall) begin
                    state_d = RX_IDLE;
                    if (dat_sync && (^{shift_q, par_q})) valid_d = 1'b1;
                    else                                  error_d = 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase

        if (state_q != RX_IDLE && !fall && tmo_q == TCW'(TIMEOUT_CYCLES - 1)) begin
            state_d = RX_IDLE;
            error_d = 1'b1;
        end
    end

    assign rx_byte = shift_q;

endmodule

// File: rtl/ps2_keyboard.sv
// rtl/ps2_keyboard.sv - PS/2 keyboard to Hack keycode (KBD register source)
// Ports: clk (clk_out), reset (sync, active high), ps2_clk/ps2_data (raw PMOD pins),
// kbd (ps2_keyboard_if.master: keycode[15:0], byte_valid, frame_error).
// Optional feature macro PS2_SHIFT_EN: track L/R shift, lowercase/uppercase letters and
// shifted US symbols; break matching then uses the scan code latched at make.
module ps2_keyboard
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           ps2_clk,
    input  logic           ps2_data,
    ps2_keyboard_if.master kbd
);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_error;

    ps2_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk         (clk),
        .reset       (reset),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .rx_byte     (rx_byte),
        .byte_valid  (rx_valid),
        .frame_error (rx_error)
    );

    function automatic key_pair_t translate(input logic ext, input logic [7:0] sc);
        key_pair_t r;
        r = '0;
        if (ext) begin
            case (sc)
                8'h6B:   r = {KEY_LEFT,   KEY_LEFT};
                8'h75:   r = {KEY_UP,     KEY_UP};
                8'h74:   r = {KEY_RIGHT,  KEY_RIGHT};
                8'h72:   r = {KEY_DOWN,   KEY_DOWN};
                8'h6C:   r = {KEY_HOME,   KEY_HOME};
                8'h69:   r = {KEY_END,    KEY_END};
                8'h7D:   r = {KEY_PGUP,   KEY_PGUP};
                8'h7A:   r = {KEY_PGDN,   KEY_PGDN};
                8'h70:   r = {KEY_INSERT, KEY_INSERT};
                8'h71:   r = {KEY_DELETE, KEY_DELETE};
                default: r = '0;
            endcase
        end else begin
            case (sc)
                8'h1C: r = {"a", "A"};  8'h32: r = {"b", "B"};  8'h21: r = {"c", "C"};
                8'h23: r = {"d", "D"};  8'h24: r = {"e", "E"};  8'h2B: r = {"f", "F"};
                8'h34: r = {"g", "G"};  8'h33: r = {"h", "H"};  8'h43: r = {"i", "I"};
                8'h3B: r = {"j", "J"};  8'h42: r = {"k", "K"};  8'h4B: r = {"l", "L"};
                8'h3A: r = {"m", "M"};  8'h31: r = {"n", "N"};  8'h44: r = {"o", "O"};
                8'h4D: r = {"p", "P"};  8'h15: r = {"q", "Q"};  8'h2D: r = {"r", "R"};
                8'h1B: r = {"s", "S"};  8'h2C: r = {"t", "T"};  8'h3C: r = {"u", "U"};
                8'h2A: r = {"v", "V"};  8'h1D: r = {"w", "W"};  8'h22: r = {"x", "X"};
                8'h35: r = {"y", "Y"};  8'h1A: r = {"z", "Z"};
                8'h16: r = {"1", "!"};  8'h1E: r = {"2", "@"};  8'h26: r = {"3", "#"};
                8'h25: r = {"4", "$"};  8'h2E: r = {"5", "%"};  8'h36: r = {"6", "^"};
                8'h3D: r = {"7", "&"};  8'h3E: r = {"8", "*"};  8'h46: r = {"9", "("};
                8'h45: r = {"0", ")"};
                8'h29: r = {8'h20, 8'h20};  8'h0E: r = {8'h60, 8'h7E};
                8'h4E: r = {"-", "_"};      8'h55: r = {"=", "+"};
                8'h54: r = {"[", "{"};      8'h5B: r = {"]", "}"};
                8'h5D: r = {8'h5C, 8'h7C};  8'h4C: r = {";", ":"};
                8'h52: r = {8'h27, 8'h22};  8'h41: r = {",", "<"};
                8'h49: r = {".", ">"};      8'h4A: r = {"/", "?"};
                8'h5A: r = {KEY_NEWLINE,   KEY_NEWLINE};
                8'h66: r = {KEY_BACKSPACE, KEY_BACKSPACE};
                8'h76: r = {KEY_ESC, KEY_ESC};
                8'h05: r = {KEY_F1,  KEY_F1};   8'h06: r = {KEY_F2,  KEY_F2};
                8'h04: r = {KEY_F3,  KEY_F3};   8'h0C: r = {KEY_F4,  KEY_F4};
                8'h03: r = {KEY_F5,  KEY_F5};   8'h0B: r = {KEY_F6,  KEY_F6};
                8'h83: r = {KEY_F7,  KEY_F7};   8'h0A: r = {KEY_F8,  KEY_F8};
                8'h01: r = {KEY_F9,  KEY_F9};   8'h09: r = {KEY_F10, KEY_F10};
                8'h78: r = {KEY_F11, KEY_F11};  8'h07: r = {KEY_F12, KEY_F12};
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    logic       brk_q, ext_q;
    logic [2:0] skip_q;
    logic [7:0] key_q;
    key_pair_t  kp;
    logic [7:0] trans;

`ifdef PS2_SHIFT_EN
    logic       shift_l_q, shift_r_q;
    logic [8:0] held_q;

    always_comb begin
        kp    = translate(ext_q, rx_byte);
        trans = (shift_l_q || shift_r_q) ? kp.upper : kp.plain;
    end
`else
    // Without shift tracking letters are reported uppercase, everything else unshifted.
    always_comb begin
        kp    = translate(ext_q, rx_byte);
        trans = (kp.plain >= 8'h61 && kp.plain <= 8'h7A) ? kp.upper : kp.plain;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            brk_q     <= 1'b0;
            ext_q     <= 1'b0;
            skip_q    <= '0;
            key_q     <= '0;
`ifdef PS2_SHIFT_EN
            shift_l_q <= 1'b0;
            shift_r_q <= 1'b0;
            held_q    <= '0;
`endif
        end else if (rx_valid) begin
            if (skip_q != 3'd0) begin
                // Remainder of the Pause sequence carries no key state.
                skip_q <= skip_q - 3'd1;
            end else if (rx_byte == SC_BREAK) begin
                brk_q <= 1'b1;
            end else if (rx_byte == SC_EXT) begin
                ext_q <= 1'b1;
            end else if (rx_byte == SC_PAUSE) begin
                skip_q <= 3'd7;
                brk_q  <= 1'b0;
                ext_q  <= 1'b0;
            end else begin
                brk_q <= 1'b0;
                ext_q <= 1'b0;
`ifdef PS2_SHIFT_EN
                if (!ext_q && rx_byte == SC_LSHIFT) begin
                    shift_l_q <= !brk_q;
                end else if (!ext_q && rx_byte == SC_RSHIFT) begin
                    shift_r_q <= !brk_q;
                end else if (brk_q) begin
                    // Compare raw codes so the shift state at release does not matter.
                    if ({ext_q, rx_byte} == held_q) key_q <= '0;
                end else if (trans != 8'h00) begin
                    key_q  <= trans;
                    held_q <= {ext_q, rx_byte};
                end
`else
                if (brk_q) begin
                    if (trans == key_q) key_q <= '0;
                end else if (trans != 8'h00) begin
                    key_q <= trans;
                end
`endif
            end
        end
    end

    assign kbd.keycode     = {8'h00, key_q};
    assign kbd.byte_valid  = rx_valid;
    assign kbd.frame_error = rx_error;

endmodule
